// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation helpers for the multi-lane MAC engine.
package mac_pkg;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int unsigned DEF_OUT_W = 16;
  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned WIDE_W    = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Signed range limits of a w-bit two's complement value.
  function automatic wide_t s_max(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t s_min(input int unsigned w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic fits_signed(input wide_t x, input int unsigned w);
    return (x <= s_max(w)) && (x >= s_min(w));
  endfunction

  function automatic wide_t clamp_signed(input wide_t x, input int unsigned w);
    if (x > s_max(w)) return s_max(w);
    else if (x < s_min(w)) return s_min(w);
    else return x;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC lane: product register, saturating/wrapping accumulator,
// sticky overflow and round-half-up requantiser.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               beat_i,
  input  logic               acc_en_i,
  input  logic               sat_en_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               load_i,
  input  logic               done_i,
  input  logic [IN_W-1:0]    a_i,
  input  logic [IN_W-1:0]    w_i,
  output logic [OUT_W-1:0]   out_o,
  output logic               ovf_o
);

  localparam int unsigned PROD_W = 2 * IN_W;

  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     ovf_q;

  wide_t sum_c;
  wide_t rnd_c;
  wide_t quant_c;
  logic  acc_fit_c;
  logic  out_fit_c;

  // Wide arithmetic so range checks see the true result before truncation.
  always_comb begin
    sum_c     = wide_t'(acc_q) + wide_t'(prod_q);
    acc_fit_c = fits_signed(sum_c, ACC_W);
    rnd_c     = (shift_i != '0) ? (wide_t'(1) <<< (shift_i - SHIFT_W'(1))) : '0;
    quant_c   = (wide_t'(acc_q) + rnd_c) >>> shift_i;
    out_fit_c = fits_signed(quant_c, OUT_W);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      out_o  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (beat_i) prod_q <= PROD_W'($signed(a_i)) * PROD_W'($signed(w_i));

      if (clr_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (acc_en_i) begin
        acc_q <= (!acc_fit_c && sat_en_i) ? ACC_W'(clamp_signed(sum_c, ACC_W)) : ACC_W'(sum_c);
        if (!acc_fit_c) ovf_q <= 1'b1;
      end

      // Result and flag are only meaningful while the result is offered.
      if (load_i) begin
        out_o <= OUT_W'(clamp_signed(quant_c, OUT_W));
        ovf_o <= ovf_q | ~out_fit_c;
      end else if (done_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// Multi-lane MAC engine: shared run FSM, beat counter and handshakes over LANES mac_lane instances.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       acc_len_i,
  input  logic [4:0]             shift_i,
  input  logic                   sat_en_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*IN_W-1:0]  in_data_i,
  input  logic [LANES*IN_W-1:0]  weight_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [LANES-1:0]       ovf_o,
  output logic                   busy_o
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               sat_q;
  logic               prod_vld_q;

  logic start_ok_c;
  logic beat_c;
  logic load_c;
  logic out_hs_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DRAIN holds until the final product has been folded into the accumulators.
  always_comb begin
    start_ok_c = 1'b0;
    beat_c     = 1'b0;
    load_c     = 1'b0;
    out_hs_c   = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        start_ok_c = start_i && (acc_len_i != '0);
        if (start_ok_c) state_d = ACCUM;
      end
      ACCUM: begin
        beat_c = in_valid_i;
        if (beat_c && (cnt_q == len_q - LEN_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        load_c = !prod_vld_q;
        if (load_c) state_d = OUT;
      end
      OUT: begin
        out_hs_c = out_ready_i;
        if (out_hs_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      sat_q       <= 1'b0;
      prod_vld_q  <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      prod_vld_q  <= beat_c;
      in_ready_o  <= (state_d == ACCUM);
      out_valid_o <= (state_d == OUT);
      busy_o      <= (state_d != IDLE);
      if (start_ok_c) begin
        len_q   <= acc_len_i;
        shift_q <= shift_i;
        sat_q   <= sat_en_i;
        cnt_q   <= '0;
      end else if (beat_c) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .IN_W (IN_W),
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (start_ok_c),
      .beat_i  (beat_c),
      .acc_en_i(prod_vld_q),
      .sat_en_i(sat_q),
      .shift_i (shift_q),
      .load_i  (load_c),
      .done_i  (out_hs_c),
      .a_i     (in_data_i[l*IN_W +: IN_W]),
      .w_i     (weight_i[l*IN_W +: IN_W]),
      .out_o   (out_data_o[l*OUT_W +: OUT_W]),
      .ovf_o   (ovf_o[l])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Randomised and directed bench for mac_lane_array; a 32-bit and a 17-bit accumulator
// instance share stimulus and are checked against an integer reference model.
module tb_mac_lane_array;

  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int NDUT  = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   start_i = 1'b0;
  logic [7:0]             acc_len_i = '0;
  logic [4:0]             shift_i = '0;
  logic                   sat_en_i = 1'b0;
  logic                   in_valid_i = 1'b0;
  logic [LANES*IN_W-1:0]  in_data_i = '0;
  logic [LANES*IN_W-1:0]  weight_i = '0;
  logic                   out_ready_i = 1'b0;

  logic [NDUT-1:0]        in_ready;
  logic [NDUT-1:0]        out_valid;
  logic [NDUT-1:0]        busy;
  logic [LANES*OUT_W-1:0] out_data [NDUT];
  logic [LANES-1:0]       ovf [NDUT];

  int checks = 0;
  int errors = 0;

  int     beat_a[$];
  int     beat_w[$];
  longint exp_out [NDUT][LANES];
  bit     exp_ovf [NDUT][LANES];

  always #5 clk_i = ~clk_i;

  mac_lane_array #(.ACC_W(32)) u_dut32 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .acc_len_i(acc_len_i),
    .shift_i(shift_i), .sat_en_i(sat_en_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready[0]), .in_data_i(in_data_i), .weight_i(weight_i),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i), .out_data_o(out_data[0]),
    .ovf_o(ovf[0]), .busy_o(busy[0])
  );

  mac_lane_array #(.ACC_W(17)) u_dut17 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .acc_len_i(acc_len_i),
    .shift_i(shift_i), .sat_en_i(sat_en_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready[1]), .in_data_i(in_data_i), .weight_i(weight_i),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i), .out_data_o(out_data[1]),
    .ovf_o(ovf[1]), .busy_o(busy[1])
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint lane_val(input logic [LANES*OUT_W-1:0] bus, input int l);
    logic signed [OUT_W-1:0] v;
    v = bus[l*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  function automatic int acc_w_of(input int d);
    return (d == 0) ? 32 : 17;
  endfunction

  // Reference: exact integer sums, range applied after each beat, then rounded division.
  task automatic model(input int len, input int sh, input bit sat);
    longint acc, hi, lo, m, q, rnd;
    bit     ov;
    for (int d = 0; d < NDUT; d++) begin
      hi = (longint'(1) <<< (acc_w_of(d) - 1)) - 1;
      lo = -(longint'(1) <<< (acc_w_of(d) - 1));
      m  = longint'(1) <<< acc_w_of(d);
      for (int l = 0; l < LANES; l++) begin
        acc = 0;
        ov  = 1'b0;
        for (int b = 0; b < len; b++) begin
          acc += longint'(beat_a[b*LANES+l]) * longint'(beat_w[b*LANES+l]);
          if (acc > hi || acc < lo) begin
            ov = 1'b1;
            if (sat) acc = (acc > hi) ? hi : lo;
            else begin
              acc = acc % m;
              if (acc < 0) acc += m;
              if (acc > hi) acc -= m;
            end
          end
        end
        rnd = (sh != 0) ? (longint'(1) <<< (sh - 1)) : 0;
        q = (acc + rnd) >>> sh;
        if (q > 32767)  begin q = 32767;  ov = 1'b1; end
        if (q < -32768) begin q = -32768; ov = 1'b1; end
        exp_out[d][l] = q;
        exp_ovf[d][l] = ov;
      end
    end
  endtask

  task automatic check_result(input string tag);
    longint ov_exp;
    for (int d = 0; d < NDUT; d++) begin
      ov_exp = 0;
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("%s_d%0d_lane%0d", tag, d, l), lane_val(out_data[d], l), exp_out[d][l]);
        if (exp_ovf[d][l]) ov_exp |= longint'(1) << l;
      end
      chk($sformatf("%s_d%0d_ovf", tag, d), longint'(ovf[d]), ov_exp);
    end
  endtask

  // Full run: start, beats (optionally 1-0-1-0 valid), drain timing, held output, handshake.
  task automatic do_run(input string tag, input int len, input int sh, input bit sat,
                        input bit gaps, input int hold);
    int i, cyc;
    model(len, sh, sat);
    @(negedge clk_i);
    start_i = 1'b1; acc_len_i = 8'(len); shift_i = 5'(sh); sat_en_i = sat;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_ready_after_start"}, longint'(in_ready[d]), 1);
      chk({tag, "_busy_after_start"}, longint'(busy[d]), 1);
    end
    i = 0; cyc = 0;
    while (i < len) begin
      in_valid_i = !gaps || (cyc % 2 == 0);
      if (in_valid_i) begin
        for (int l = 0; l < LANES; l++) begin
          in_data_i[l*IN_W +: IN_W] = 8'(beat_a[i*LANES+l]);
          weight_i[l*IN_W +: IN_W]  = 8'(beat_w[i*LANES+l]);
        end
      end else begin
        in_data_i = 32'($urandom);
        weight_i  = 32'($urandom);
      end
      @(negedge clk_i);
      if (in_valid_i) i++;
      cyc++;
    end
    in_valid_i = 1'b1;
    in_data_i  = 32'($urandom);
    weight_i   = 32'($urandom);
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_drain_ready"}, longint'(in_ready[d]), 0);
      chk({tag, "_drain_valid0"}, longint'(out_valid[d]), 0);
    end
    @(negedge clk_i);
    chk({tag, "_drain_valid1"}, longint'(out_valid), 0);
    @(negedge clk_i);
    chk({tag, "_out_valid"}, longint'(out_valid), 3);
    check_result(tag);
    for (int h = 0; h < hold; h++) begin
      start_i = 1'b1; acc_len_i = 8'd3;
      @(negedge clk_i);
      chk({tag, "_hold_valid"}, longint'(out_valid), 3);
      check_result({tag, "_hold"});
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk({tag, "_post_valid"}, longint'(out_valid), 0);
    chk({tag, "_post_busy"}, longint'(busy), 0);
    chk({tag, "_post_ovf"}, longint'({ovf[1], ovf[0]}), 0);
  endtask

  task automatic fill_same(input int a0, input int w0, input int b);
    for (int l = 0; l < LANES; l++) begin
      beat_a[b*LANES+l] = a0;
      beat_w[b*LANES+l] = w0;
    end
  endtask

  task automatic prep(input int len);
    beat_a.delete(); beat_w.delete();
    for (int k = 0; k < len * LANES; k++) begin
      beat_a.push_back(0);
      beat_w.push_back(0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, sh;
    repeat (3) @(negedge clk_i);
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_ready", longint'(in_ready[d]), 0);
      chk("rst_valid", longint'(out_valid[d]), 0);
      chk("rst_busy", longint'(busy[d]), 0);
      chk("rst_data", longint'(out_data[d]), 0);
      chk("rst_ovf", longint'(ovf[d]), 0);
    end
    rst_i = 1'b0;

    prep(3); fill_same(1, 2, 0); fill_same(3, 4, 1); fill_same(-5, 6, 2);
    do_run("basic", 3, 0, 1'b1, 1'b0, 0);

    prep(4); fill_same(1, 2, 0); fill_same(3, 4, 1); fill_same(-5, 6, 2); fill_same(7, -1, 3);
    do_run("stall", 4, 0, 1'b1, 1'b1, 5);

    prep(1); fill_same(7, 3, 0);
    do_run("round_pos", 1, 2, 1'b1, 1'b0, 0);
    prep(1); fill_same(-7, 3, 0);
    do_run("round_neg", 1, 2, 1'b1, 1'b0, 0);

    prep(4); for (int b = 0; b < 4; b++) fill_same(127, 127, b);
    do_run("clamp_pos", 4, 0, 1'b1, 1'b0, 1);
    prep(4); for (int b = 0; b < 4; b++) fill_same(-128, 127, b);
    do_run("clamp_neg", 4, 0, 1'b1, 1'b0, 0);

    prep(5); for (int b = 0; b < 5; b++) fill_same(127, 127, b);
    do_run("acc_sat", 5, 0, 1'b1, 1'b0, 0);
    do_run("acc_wrap", 5, 0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 24; r++) begin
      len = int'($urandom_range(1, 12));
      sh  = int'($urandom_range(0, 18));
      beat_a.delete(); beat_w.delete();
      for (int k = 0; k < len * LANES; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          beat_a.push_back(($urandom_range(0, 1) != 0) ? 127 : -128);
          beat_w.push_back(($urandom_range(0, 1) != 0) ? 127 : -128);
        end else begin
          beat_a.push_back(int'($urandom_range(0, 255)) - 128);
          beat_w.push_back(int'($urandom_range(0, 255)) - 128);
        end
      end
      do_run($sformatf("rand%0d", r), len, sh, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of accumulation discards the run.
    @(negedge clk_i);
    start_i = 1'b1; acc_len_i = 8'd5; shift_i = 5'd0; sat_en_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h7f7f7f7f; weight_i = 32'h7f7f7f7f;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("midrst_ready", longint'(in_ready[d]), 0);
      chk("midrst_valid", longint'(out_valid[d]), 0);
      chk("midrst_busy", longint'(busy[d]), 0);
      chk("midrst_data", longint'(out_data[d]), 0);
      chk("midrst_ovf", longint'(ovf[d]), 0);
    end
    @(negedge clk_i);
    rst_i = 1'b0; in_valid_i = 1'b0;

    // Zero-length start is ignored.
    start_i = 1'b1; acc_len_i = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("zero_len_busy", longint'(busy), 0);
    chk("zero_len_ready", longint'(in_ready), 0);
    chk("zero_len_valid", longint'(out_valid), 0);

    prep(2); fill_same(-128, -128, 0); fill_same(5, -9, 1);
    do_run("after_rst", 2, 3, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_lane_array.md
# mac_lane_array

Parametrised multi-lane multiply-accumulate engine: LANES independent signed MAC lanes share one control FSM that accumulates a run-time-programmed number of beats, then requantises each accumulator with round-half-up shift and saturation to OUT_W. It is the next-generation compute core for the recursive-architecture controller. It replaces single-lane, externally-sequenced MACs with valid/ready input and output handshakes, an internal beat counter, and overflow reporting.

## Interface
- LANES, 4, number of parallel MAC lanes
- IN_W, 8, signed activation and weight width
- ACC_W, 32, signed accumulator width (must be ≥ 2*IN_W+1)
- OUT_W, 16, signed requantised output width (≤ ACC_W)
- LEN_W, 8, width of the beat-count field
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a run; accepted only in IDLE
- acc_len_i  in  LEN_W  beats per run, sampled on accepted start; 0 ⇒ start ignored
- shift_i  in  5  requantise right-shift, sampled on accepted start
- sat_en_i  in  1  1 = accumulator saturates at ACC_W, 0 = wraps; sampled on start
- in_valid_i / in_ready_o  in / out  1  input beat handshake
- in_data_i  in  LANES*IN_W  packed signed activations, lane 0 in LSBs
- weight_i  in  LANES*IN_W  packed signed weights, per lane
- out_valid_o / out_ready_i  out / in  1  result handshake
- out_data_o  out  LANES*OUT_W  packed signed results
- ovf_o  out  LANES  per-lane sticky overflow flag for the run (accumulate or requantise)
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → ACCUM → DRAIN → OUT → IDLE.
- IDLE: start_i && acc_len_i≠0 latches len/shift/sat_en, clears accumulators, beat counter and ovf, enters ACCUM.
- ACCUM: in_ready_o = 1; each handshake multiplies per lane (full 2*IN_W product, registered) and increments the counter; on the handshake with counter = len-1, go to DRAIN.
- DRAIN: in_ready_o = 0; waits 1 cycle for the last product to reach the accumulator, then computes outputs and enters OUT.
- Accumulate: acc + sign-extended product computed at ACC_W+1; if result exceeds the ACC_W range, set ovf[lane]; sat_en=1 clamps to max/min, sat_en=0 keeps the low ACC_W bits.
- Requantise: (acc + (shift≠0 ? 1<<(shift-1) : 0)) >>> shift, computed at ACC_W+1 bits; clamp to the OUT_W signed range, set ovf[lane] if clamped.
- OUT: out_valid_o = 1, out_data_o and ovf_o held stable until out_ready_i; on handshake go to IDLE and drop out_valid_o.
- start_i outside IDLE ignored; in_valid_i outside ACCUM ignored (no beat consumed).
- Reset at any time: state IDLE, all registers zero, in-flight run discarded.

## Timing
- Reset values: in_ready_o=0, out_valid_o=0, out_data_o=0, ovf_o=0, busy_o=0.
- Accepted start at edge t: ACCUM and in_ready_o=1 from t; first beat may be accepted at edge t+1.
- Last beat accepted at edge k: product registered at k, accumulated at k+1 (DRAIN), output registered with out_valid_o=1 from edge k+2.
- Throughput: 1 beat/cycle in ACCUM with no bubbles; no overlap between runs: next start is earliest at the cycle after the output handshake.
- out_ready_i high while out_valid_o rises: handshake on edge k+3, IDLE from k+3.
- ovf_o is valid only while out_valid_o=1; it is undefined-free (holds 0) otherwise.

## Structure
- Shared package mac_pkg: FSM state enum (IDLE, ACCUM, DRAIN, OUT), saturate/clamp helper functions, and default width constants.
- One sub-module, mac_lane: the product register, accumulator with sat/wrap, ovf flag and requantiser; instantiated LANES times via generate. The top holds the FSM, counter and handshakes.

## Test plan
- Basic: LANES=4, len=3, shift=0, beats (in,w) = (1,2),(3,4),(-5,6) on all lanes → out_data each lane = -16, ovf=0, out_valid at last-beat edge+2.
- Stall: in_valid toggled 1-0-1-0, len=4 → counter advances only on handshakes, same result as back-to-back; out_ready held low 5 cycles → data stable, no new start accepted.
- Rounding: len=1, in=7, w=3 (21), shift=2 → 5; in=-7, w=3 (-21), shift=2 → -5.
- Clamp: OUT_W=16, len=4, in=127, w=127 → acc 64516, out 32767, ovf=1; negative mirror (-128, 127) → -32768, ovf=1.
- Accumulator sat vs wrap: ACC_W=17, len=5, 127*127 → sat_en=1 acc=65535, sat_en=0 wraps; ovf=1 both.
- Reset mid-ACCUM after 2 beats, and start with acc_len_i=0 → all outputs 0, IDLE; zero-length start leaves busy_o=0.
